ct_ifu_icache_data_refill_ctrl: RTL and testbench
=================================================

CT_IFU_ICACHE_DATA_REFILL_CTRL -- requirements
Module: ct_ifu_icache_data_refill_ctrl

Interface
REQ-001 SHALL have input forever_cpuclk, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have input cpurst, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have input refill_req_vld, 1 bit, and output refill_req_rdy, 1 bit: line-refill start handshake.
REQ-004 SHALL have input refill_index, 16 bits: line address; bits [5:0] ignored.
REQ-005 SHALL have input refill_data_vld, 1 bit, input refill_data, 128 bits, and output refill_data_rdy, 1 bit: beat handshake.
REQ-006 SHALL have input fetch_rd_req, 1 bit, input fetch_rd_index, 16 bits, and output fetch_rd_gnt, 1 bit: fetch read port.
REQ-007 SHALL have outputs ifu_icache_data_array0_bank{0..3}_cen_b, 1 bit each: active-low bank chip enables.
REQ-008 SHALL have outputs ifu_icache_data_array0_bank{0..3}_clk_en, 1 bit each: bank gated-clock enables.
REQ-009 SHALL have outputs ifu_icache_data_array0_wen_b (1 bit, active-low write), ifu_icache_data_array0_din (128 bits) and ifu_icache_index (16 bits).
REQ-010 SHALL have outputs refill_busy (1 bit, level) and refill_done (1 bit, one-cycle pulse).

Function
REQ-011 SHALL implement FSM IDLE -> WRITE -> DONE -> IDLE.
REQ-012 In IDLE, refill_req_rdy SHALL be 1; on refill_req_vld&&refill_req_rdy the block SHALL latch refill_index[15:6], clear the 2-bit beat counter and enter WRITE.
REQ-013 In WRITE, refill_data_rdy SHALL be 1 unless a fetch wins arbitration (REQ-018); a beat SHALL be accepted on refill_data_vld&&refill_data_rdy.
REQ-014 On an accepted beat, in the same cycle: all four cen_b=0, wen_b=0, all clk_en=1, din=refill_data, ifu_icache_index={latched[15:6], beat_cnt[1:0], 4'b0}.
REQ-015 The beat counter SHALL increment per accepted beat; the accepted beat with beat_cnt=3 SHALL move the FSM to DONE, and the counter SHALL wrap to 0.
REQ-016 DONE SHALL last exactly one cycle with refill_done=1, then return to IDLE; refill_req_rdy=0 in DONE.
REQ-017 refill_busy SHALL be 1 in WRITE and DONE.
REQ-018 A fetch SHALL be granted (fetch_rd_gnt=1) when fetch_rd_req=1 and no write occurs that cycle; then all cen_b=0, wen_b=1, clk_en=1, ifu_icache_index=fetch_rd_index. Read data returns from the array one cycle later, not via this block.
REQ-019 On the same-cycle collision of a WRITE beat (refill_data_vld=1) and fetch_rd_req=1, the write SHALL win by default: fetch_rd_gnt=0.
REQ-020 When neither a read nor a write occurs: all cen_b=1, wen_b=1, clk_en=0; din and ifu_icache_index SHALL hold their last driven values.
REQ-021 refill_req_vld outside IDLE SHALL be ignored and not queued.

Reset
REQ-022 While cpurst=1: FSM=IDLE, beat counter=0, starvation counter=0, all cen_b=1, wen_b=1, all clk_en=0, din=0, ifu_icache_index=0, refill_req_rdy=0, refill_data_rdy=0, fetch_rd_gnt=0, refill_busy=0, refill_done=0.
REQ-023 cpurst asserted mid-refill SHALL abandon the line without issuing refill_done; the first cycle after deassertion SHALL be IDLE with refill_req_rdy=1.

Configuration
REQ-024 Macro ICACHE_REFILL_STARVE_GUARD_EN defined: a 2-bit counter SHALL count consecutive cycles with fetch_rd_req=1 and fetch_rd_gnt=0; at value 2 the next colliding cycle SHALL grant the fetch and force refill_data_rdy=0; the counter SHALL clear on any grant or on fetch_rd_req=0.
REQ-025 Macro undefined: no counter; writes always win (REQ-019).

Structure
REQ-026 FSM state encoding, beat-count width (2), line-offset width (6) and bank count (4) SHALL live in package ct_ifu_icache_pkg.
REQ-027 The block SHALL be flat except for one optional sub-module ct_ifu_icache_refill_arb (read/write arbitration plus starvation counter).

Verification
REQ-028 Refill index 16'h1240, 4 back-to-back beats A0..A3 -> writes at indices 16'h1240, 16'h1250, 16'h1260, 16'h1270; refill_done exactly one cycle after the A3 write.
REQ-029 Fetch_rd_req held during a 4-beat refill, guard undefined -> fetch_rd_gnt=0 for 4 cycles, then 1 in the DONE cycle.
REQ-030 Same stimulus, ICACHE_REFILL_STARVE_GUARD_EN defined -> write, write, fetch grant with refill_data_rdy=0, then the remaining writes.
REQ-031 refill_data_vld gapped (beat, 3 idle cycles, beat) -> idle cycles give cen_b=1111 and clk_en=0000; beat count and indices stay correct.
REQ-032 cpurst pulsed after beat 1 -> no refill_done; next cycle refill_req_rdy=1; a new refill starts with beat 0 index.
REQ-033 refill_req_vld asserted during WRITE -> ignored; refill_req_rdy=0 until the cycle after DONE.

Source files
------------

// File: rtl/ct_ifu_icache_pkg.sv
// Shared types and geometry for the icache data-array refill controller.
package ct_ifu_icache_pkg;
  localparam int INDEX_W    = 16;
  localparam int DATA_W     = 128;
  localparam int BEAT_W     = 2;
  localparam int LINE_OFF_W = 6;
  localparam int BANK_NUM   = 4;
  localparam int BEAT_OFF_W = LINE_OFF_W - BEAT_W;

  localparam logic [BEAT_W-1:0] LAST_BEAT = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } refill_state_e;
endpackage

// File: rtl/ct_ifu_icache_refill_arb.sv
// Single-port data-array arbitration: refill write beats versus fetch reads.
// Optional ICACHE_REFILL_STARVE_GUARD_EN lets a starved fetch steal one beat slot.
module ct_ifu_icache_refill_arb (
`ifdef ICACHE_REFILL_STARVE_GUARD_EN
  input  logic clk,
`endif
  input  logic rst,
  input  logic in_write,
  input  logic data_vld,
  input  logic rd_req,
  output logic data_rdy,
  output logic wr_fire,
  output logic rd_gnt
);
  logic force_rd;

`ifdef ICACHE_REFILL_STARVE_GUARD_EN
  logic [1:0] starve_cnt;

  // Two consecutive refused cycles hand the next slot to the fetch.
  assign force_rd = rd_req && (starve_cnt >= 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 2'd0;
    end else if (!rd_req || rd_gnt) begin
      starve_cnt <= 2'd0;
    end else if (starve_cnt != 2'd3) begin
      starve_cnt <= starve_cnt + 2'd1;
    end
  end
`else
  assign force_rd = 1'b0;
`endif

  assign data_rdy = !rst && in_write && !force_rd;
  assign wr_fire  = data_rdy && data_vld;
  assign rd_gnt   = !rst && rd_req && !wr_fire;
endmodule

// File: rtl/ct_ifu_icache_data_refill_ctrl.sv
// Icache data-array refill controller: writes 4 beats per line, arbitrates fetch reads.
// ICACHE_REFILL_STARVE_GUARD_EN enables the fetch starvation guard in the arbiter.
module ct_ifu_icache_data_refill_ctrl
  import ct_ifu_icache_pkg::*;
(
  input  logic               forever_cpuclk,
  input  logic               cpurst,
  input  logic               refill_req_vld,
  output logic               refill_req_rdy,
  input  logic [INDEX_W-1:0] refill_index,
  input  logic               refill_data_vld,
  input  logic [DATA_W-1:0]  refill_data,
  output logic               refill_data_rdy,
  input  logic               fetch_rd_req,
  input  logic [INDEX_W-1:0] fetch_rd_index,
  output logic               fetch_rd_gnt,
  output logic               ifu_icache_data_array0_bank0_cen_b,
  output logic               ifu_icache_data_array0_bank1_cen_b,
  output logic               ifu_icache_data_array0_bank2_cen_b,
  output logic               ifu_icache_data_array0_bank3_cen_b,
  output logic               ifu_icache_data_array0_bank0_clk_en,
  output logic               ifu_icache_data_array0_bank1_clk_en,
  output logic               ifu_icache_data_array0_bank2_clk_en,
  output logic               ifu_icache_data_array0_bank3_clk_en,
  output logic               ifu_icache_data_array0_wen_b,
  output logic [DATA_W-1:0]  ifu_icache_data_array0_din,
  output logic [INDEX_W-1:0] ifu_icache_index,
  output logic               refill_busy,
  output logic               refill_done
);
  refill_state_e                 state, next_state;
  logic [INDEX_W-1:LINE_OFF_W]   line_idx;
  logic [BEAT_W-1:0]             beat_cnt;
  logic [DATA_W-1:0]             din_q;
  logic [INDEX_W-1:0]            index_q;
  logic [INDEX_W-1:0]            wr_index;
  logic [BANK_NUM-1:0]           bank_cen_b;
  logic                          req_fire, wr_fire, access;
  logic                          unused_idx_bits;

  assign unused_idx_bits = ^refill_index[LINE_OFF_W-1:0];

  ct_ifu_icache_refill_arb u_arb (
`ifdef ICACHE_REFILL_STARVE_GUARD_EN
    .clk      (forever_cpuclk),
`endif
    .rst      (cpurst),
    .in_write (state == ST_WRITE),
    .data_vld (refill_data_vld),
    .rd_req   (fetch_rd_req),
    .data_rdy (refill_data_rdy),
    .wr_fire  (wr_fire),
    .rd_gnt   (fetch_rd_gnt)
  );

  assign req_fire = refill_req_vld && refill_req_rdy;
  assign access   = wr_fire || fetch_rd_gnt;
  assign wr_index = {line_idx, beat_cnt, {BEAT_OFF_W{1'b0}}};

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state    <= ST_IDLE;
      line_idx <= '0;
      beat_cnt <= '0;
      din_q    <= '0;
      index_q  <= '0;
    end else begin
      state <= next_state;
      if (req_fire) begin
        line_idx <= refill_index[INDEX_W-1:LINE_OFF_W];
        beat_cnt <= '0;
      end else if (wr_fire) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (wr_fire) din_q <= refill_data;
      if (access)  index_q <= ifu_icache_index;
    end
  end

  always_comb begin
    next_state     = state;
    refill_req_rdy = 1'b0;
    refill_busy    = 1'b0;
    refill_done    = 1'b0;
    case (state)
      ST_IDLE: begin
        refill_req_rdy = !cpurst;
        if (req_fire) next_state = ST_WRITE;
      end
      ST_WRITE: begin
        refill_busy = !cpurst;
        if (wr_fire && beat_cnt == LAST_BEAT) next_state = ST_DONE;
      end
      ST_DONE: begin
        refill_busy = !cpurst;
        refill_done = !cpurst;
        next_state  = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Address/data buses park on their last driven value between accesses.
  always_comb begin
    ifu_icache_index           = index_q;
    ifu_icache_data_array0_din = din_q;
    if (cpurst) begin
      ifu_icache_index           = '0;
      ifu_icache_data_array0_din = '0;
    end else if (wr_fire) begin
      ifu_icache_index           = wr_index;
      ifu_icache_data_array0_din = refill_data;
    end else if (fetch_rd_gnt) begin
      ifu_icache_index           = fetch_rd_index;
    end
  end

  assign bank_cen_b                   = {BANK_NUM{~access}};
  assign ifu_icache_data_array0_wen_b = ~wr_fire;

  assign ifu_icache_data_array0_bank0_cen_b  = bank_cen_b[0];
  assign ifu_icache_data_array0_bank1_cen_b  = bank_cen_b[1];
  assign ifu_icache_data_array0_bank2_cen_b  = bank_cen_b[2];
  assign ifu_icache_data_array0_bank3_cen_b  = bank_cen_b[3];
  assign ifu_icache_data_array0_bank0_clk_en = ~bank_cen_b[0];
  assign ifu_icache_data_array0_bank1_clk_en = ~bank_cen_b[1];
  assign ifu_icache_data_array0_bank2_clk_en = ~bank_cen_b[2];
  assign ifu_icache_data_array0_bank3_clk_en = ~bank_cen_b[3];
endmodule

// File: tb/tb_ct_ifu_icache_data_refill_ctrl.sv
// Directed self-checking bench for the icache data refill controller.
module tb_ct_ifu_icache_data_refill_ctrl;
  logic         forever_cpuclk = 1'b0;
  logic         cpurst;
  logic         refill_req_vld, refill_data_vld, fetch_rd_req;
  logic [15:0]  refill_index, fetch_rd_index;
  logic [127:0] refill_data;
  logic         refill_req_rdy, refill_data_rdy, fetch_rd_gnt;
  logic         cen0, cen1, cen2, cen3, cke0, cke1, cke2, cke3;
  logic         wen_b, refill_busy, refill_done;
  logic [127:0] din;
  logic [15:0]  index;
  logic [3:0]   cen, cke;
  int           errors = 0;
  int           checks = 0;

  assign cen = {cen3, cen2, cen1, cen0};
  assign cke = {cke3, cke2, cke1, cke0};

  ct_ifu_icache_data_refill_ctrl dut (
    .forever_cpuclk                      (forever_cpuclk),
    .cpurst                              (cpurst),
    .refill_req_vld                      (refill_req_vld),
    .refill_req_rdy                      (refill_req_rdy),
    .refill_index                        (refill_index),
    .refill_data_vld                     (refill_data_vld),
    .refill_data                         (refill_data),
    .refill_data_rdy                     (refill_data_rdy),
    .fetch_rd_req                        (fetch_rd_req),
    .fetch_rd_index                      (fetch_rd_index),
    .fetch_rd_gnt                        (fetch_rd_gnt),
    .ifu_icache_data_array0_bank0_cen_b  (cen0),
    .ifu_icache_data_array0_bank1_cen_b  (cen1),
    .ifu_icache_data_array0_bank2_cen_b  (cen2),
    .ifu_icache_data_array0_bank3_cen_b  (cen3),
    .ifu_icache_data_array0_bank0_clk_en (cke0),
    .ifu_icache_data_array0_bank1_clk_en (cke1),
    .ifu_icache_data_array0_bank2_clk_en (cke2),
    .ifu_icache_data_array0_bank3_clk_en (cke3),
    .ifu_icache_data_array0_wen_b        (wen_b),
    .ifu_icache_data_array0_din          (din),
    .ifu_icache_index                    (index),
    .refill_busy                         (refill_busy),
    .refill_done                         (refill_done)
  );

  always #5 forever_cpuclk = ~forever_cpuclk;

  function automatic logic [127:0] beat_dat(input int i);
    beat_dat = {96'h0123_4567_89AB_CDEF_0011_2233, 32'(i) ^ 32'hCAFE_0000};
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
  task automatic tick;
    @(posedge forever_cpuclk);
    #1;
  endtask

  task automatic test_reset;
    cpurst = 1'b1;
    refill_req_vld = 1'b1; refill_index = 16'hFFFF;
    refill_data_vld = 1'b1; refill_data = beat_dat(99);
    fetch_rd_req = 1'b1; fetch_rd_index = 16'h1234;
    tick; tick; #2;
    checks++;
    if ({cen, cke, wen_b} !== {4'hF, 4'h0, 1'b1}) begin
      errors++; $display("FAIL reset_array_ctl: got %b expected %b", {cen, cke, wen_b}, 9'b1111_0000_1);
    end
    checks++;
    if (din !== 128'h0 || index !== 16'h0) begin
      errors++; $display("FAIL reset_buses: got din=%h index=%h expected 0/0", din, index);
    end
    checks++;
    if ({refill_req_rdy, refill_data_rdy, fetch_rd_gnt, refill_busy, refill_done} !== 5'b0) begin
      errors++; $display("FAIL reset_handshake: got %b expected 00000",
        {refill_req_rdy, refill_data_rdy, fetch_rd_gnt, refill_busy, refill_done});
    end
    refill_req_vld = 1'b0; refill_data_vld = 1'b0; fetch_rd_req = 1'b0;
    tick;
    cpurst = 1'b0; #2;
    checks++;
    if ({refill_req_rdy, refill_busy, refill_done} !== 3'b100) begin
      errors++; $display("FAIL reset_release: got %b expected 100", {refill_req_rdy, refill_busy, refill_done});
    end
    tick;
  endtask

  task automatic test_refill_basic;
    logic [15:0] exp_idx;
    refill_req_vld = 1'b1; refill_index = 16'h1240; #2;
    checks++;
    if (refill_req_rdy !== 1'b1) begin
      errors++; $display("FAIL basic_req_rdy: got %b expected 1", refill_req_rdy);
    end
    tick;
    refill_req_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      refill_data_vld = 1'b1; refill_data = beat_dat(i); #2;
      exp_idx = 16'h1240 + 16'(i * 16);
      checks++;
      if ({wen_b, cen, cke, refill_data_rdy, refill_busy, refill_done} !== {1'b0, 4'h0, 4'hF, 3'b110}) begin
        errors++; $display("FAIL basic_write_ctl beat%0d: got %b expected 0_0000_1111_110", i,
          {wen_b, cen, cke, refill_data_rdy, refill_busy, refill_done});
      end
      checks++;
      if (index !== exp_idx || din !== beat_dat(i)) begin
        errors++; $display("FAIL basic_write_addr beat%0d: got index=%h din=%h expected %h/%h", i, index, din, exp_idx, beat_dat(i));
      end
      tick;
    end
    refill_data_vld = 1'b0; #2;
    checks++;
    if ({refill_done, refill_busy, refill_req_rdy, cen} !== {3'b110, 4'hF}) begin
      errors++; $display("FAIL basic_done: got %b expected 110_1111", {refill_done, refill_busy, refill_req_rdy, cen});
    end
    tick; #2;
    checks++;
    if ({refill_done, refill_busy, refill_req_rdy} !== 3'b001) begin
      errors++; $display("FAIL basic_back_idle: got %b expected 001", {refill_done, refill_busy, refill_req_rdy});
    end
    checks++;
    if (index !== 16'h1270 || din !== beat_dat(3)) begin
      errors++; $display("FAIL basic_hold: got index=%h din=%h expected 1270/%h", index, din, beat_dat(3));
    end
    tick;
  endtask

  task automatic test_fetch_collision;
    logic [5:0]  gpat;
    int          ncyc;
    int          b;
    logic [15:0] exp_idx;
`ifdef ICACHE_REFILL_STARVE_GUARD_EN
    gpat = 6'b100100; ncyc = 6;
`else
    gpat = 6'b010000; ncyc = 5;
`endif
    b = 0;
    fetch_rd_req = 1'b1; fetch_rd_index = 16'h0ABC;
    refill_req_vld = 1'b1; refill_index = 16'h2000; #2;
    checks++;
    if ({fetch_rd_gnt, wen_b, cen, cke} !== {2'b11, 4'h0, 4'hF} || index !== 16'h0ABC) begin
      errors++; $display("FAIL fetch_idle_grant: got %b index=%h expected 11_0000_1111 index=0abc",
        {fetch_rd_gnt, wen_b, cen, cke}, index);
    end
    tick;
    refill_req_vld = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      refill_data_vld = (k != ncyc - 1); refill_data = beat_dat(10 + b); #2;
      exp_idx = 16'h2000 + 16'(b * 16);
      checks++;
      if (k == ncyc - 1) begin
        if ({refill_done, fetch_rd_gnt, wen_b} !== 3'b111) begin
          errors++; $display("FAIL collide_done_grant: got %b expected 111", {refill_done, fetch_rd_gnt, wen_b});
        end
      end else if (gpat[k]) begin
        if ({fetch_rd_gnt, refill_data_rdy, wen_b} !== 3'b101 || index !== 16'h0ABC) begin
          errors++; $display("FAIL collide_starve_grant cyc%0d: got %b index=%h expected 101 index=0abc",
            k, {fetch_rd_gnt, refill_data_rdy, wen_b}, index);
        end
      end else begin
        if ({fetch_rd_gnt, refill_data_rdy, wen_b} !== 3'b010 || index !== exp_idx) begin
          errors++; $display("FAIL collide_write_wins cyc%0d: got %b index=%h expected 010 index=%h",
            k, {fetch_rd_gnt, refill_data_rdy, wen_b}, index, exp_idx);
        end
        b++;
      end
      tick;
    end
    fetch_rd_req = 1'b0; #2;
    checks++;
    if ({refill_req_rdy, refill_busy, fetch_rd_gnt} !== 3'b100) begin
      errors++; $display("FAIL collide_end: got %b expected 100", {refill_req_rdy, refill_busy, fetch_rd_gnt});
    end
    tick;
  endtask

  task automatic test_gapped;
    logic [6:0]  pat;
    int          b;
    logic [15:0] exp_idx;
    pat = 7'b1110001;
    b = 0;
    refill_req_vld = 1'b1; refill_index = 16'h127F;
    tick;
    refill_req_vld = 1'b0;
    for (int k = 0; k < 7; k++) begin
      refill_data_vld = pat[k]; refill_data = beat_dat(20 + k); #2;
      exp_idx = 16'h1240 + 16'(b * 16);
      checks++;
      if (pat[k]) begin
        if ({wen_b, cen, cke} !== {1'b0, 4'h0, 4'hF} || index !== exp_idx || din !== beat_dat(20 + k)) begin
          errors++; $display("FAIL gap_write cyc%0d: got %b index=%h expected 0_0000_1111 index=%h",
            k, {wen_b, cen, cke}, index, exp_idx);
        end
        b++;
      end else begin
        if ({wen_b, cen, cke, refill_data_rdy} !== {1'b1, 4'hF, 4'h0, 1'b1} || index !== 16'h1240 || din !== beat_dat(20)) begin
          errors++; $display("FAIL gap_idle cyc%0d: got %b index=%h expected 1_1111_0000_1 index=1240",
            k, {wen_b, cen, cke, refill_data_rdy}, index);
        end
      end
      tick;
    end
    refill_data_vld = 1'b0; #2;
    checks++;
    if (refill_done !== 1'b1) begin
      errors++; $display("FAIL gap_done: got %b expected 1", refill_done);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    refill_req_vld = 1'b1; refill_index = 16'h3000;
    tick;
    refill_req_vld = 1'b0;
    for (int i = 0; i < 2; i++) begin
      refill_data_vld = 1'b1; refill_data = beat_dat(30 + i); #2;
      checks++;
      if (index !== 16'h3000 + 16'(i * 16) || wen_b !== 1'b0) begin
        errors++; $display("FAIL rstmid_beat%0d: got index=%h wen_b=%b expected %h/0", i, index, wen_b, 16'h3000 + 16'(i * 16));
      end
      tick;
    end
    cpurst = 1'b1; refill_data = beat_dat(32); #2;
    checks++;
    if ({refill_done, refill_data_rdy, refill_busy, cen} !== {3'b000, 4'hF}) begin
      errors++; $display("FAIL rstmid_in_reset: got %b expected 000_1111", {refill_done, refill_data_rdy, refill_busy, cen});
    end
    tick;
    cpurst = 1'b0; refill_data_vld = 1'b0;
    refill_req_vld = 1'b1; refill_index = 16'h4000; #2;
    checks++;
    if ({refill_req_rdy, refill_busy, refill_done} !== 3'b100) begin
      errors++; $display("FAIL rstmid_release: got %b expected 100", {refill_req_rdy, refill_busy, refill_done});
    end
    tick;
    refill_req_vld = 1'b0; refill_data_vld = 1'b1; refill_data = beat_dat(40); #2;
    checks++;
    if (index !== 16'h4000 || wen_b !== 1'b0) begin
      errors++; $display("FAIL rstmid_restart: got index=%h wen_b=%b expected 4000/0", index, wen_b);
    end
    tick;
    for (int i = 1; i < 4; i++) tick;
    refill_data_vld = 1'b0; #2;
    checks++;
    if (refill_done !== 1'b1) begin
      errors++; $display("FAIL rstmid_done: got %b expected 1", refill_done);
    end
    tick;
  endtask

  task automatic test_req_ignored;
    refill_req_vld = 1'b1; refill_index = 16'h5000;
    tick;
    refill_index = 16'h6000;
    for (int i = 0; i < 4; i++) begin
      refill_data_vld = 1'b1; refill_data = beat_dat(50 + i); #2;
      checks++;
      if (refill_req_rdy !== 1'b0 || index !== 16'h5000 + 16'(i * 16)) begin
        errors++; $display("FAIL ignore_write%0d: got rdy=%b index=%h expected 0/%h", i, refill_req_rdy, index, 16'h5000 + 16'(i * 16));
      end
      tick;
    end
    refill_data_vld = 1'b0; #2;
    checks++;
    if ({refill_req_rdy, refill_done} !== 2'b01) begin
      errors++; $display("FAIL ignore_done: got %b expected 01", {refill_req_rdy, refill_done});
    end
    refill_req_vld = 1'b0;
    tick; #2;
    checks++;
    if ({refill_req_rdy, refill_busy} !== 2'b10) begin
      errors++; $display("FAIL ignore_after_done: got %b expected 10", {refill_req_rdy, refill_busy});
    end
    tick; #2;
    checks++;
    if (refill_busy !== 1'b0) begin
      errors++; $display("FAIL ignore_not_queued: got busy=%b expected 0", refill_busy);
    end
    tick;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_refill_basic;
    test_fetch_collision;
    test_gapped;
    test_reset_mid;
    test_req_ignored;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
